ibex_instr_realigner: RTL and testbench
=======================================

Name: ibex_instr_realigner

Overview:
Sits between the prefetch FIFO and the compressed decoder in the IF stage. It accepts 32-bit word-aligned fetch words and emits one instruction per handshake: either a 16-bit compressed parcel or a 32-bit instruction. A 32-bit instruction may straddle two fetch words. The block holds the leftover upper half-word, sequences refetch after a branch to a half-word address, and propagates fetch errors. Its output feeds instr_i of the compressed decoder.

Parameters:
ResetAll, 0, 1 = output data and residual registers are also reset (valid and state bits are always reset).

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  branch/exception redirect; discards all held state
flush_addr_i  in  32  redirect target; bit 0 is ignored, bit 1 selects the half-word
in_valid_i  in  1  fetch word valid
in_ready_o  out  1  block consumes the word this cycle
in_rdata_i  in  32  fetch word
in_addr_i  in  32  word address (bits [1:0] == 0)
in_err_i  in  1  bus error on this word
out_valid_o  out  1  instruction valid
out_ready_i  in  1  ID stage accepts the instruction
out_instr_o  out  32  instruction; upper 16 bits are zero when compressed
out_addr_o  out  32  PC of the instruction
out_is_compressed_o  out  1  instr[1:0] != 2'b11
out_err_o  out  1  fetch error for this instruction
out_err_plus2_o  out  1  error lies in the second half of an unaligned 32-bit instruction

Behaviour:
- Compressed test: a parcel p is compressed iff p[1:0] != 2'b11.
- Output is a single registered stage:
  - Loaded when it is empty or is being drained (out_valid_o && out_ready_i).
  - Latency: input word to out_valid_o is 1 cycle.
- Reset values:
  - out_valid_o = 0 and state = ALIGNED.
  - in_ready_o follows combinationally from the reset state.
  - Data outputs are 0 when ResetAll = 1, otherwise unspecified.
- FSM states: ALIGNED, HALF (16-bit residual R and its address RA held), SKIP_LO, ERR.
- ALIGNED, word W accepted:
  - W[1:0] == 11: emit W at in_addr_i; stay in ALIGNED.
  - Otherwise: emit {16'h0, W[15:0]}; R = W[31:16]; RA = addr+2; go to HALF.
- HALF:
  - R compressed: emit R at RA without consuming input (in_ready_o = 0); go to ALIGNED.
  - R uncompressed: wait for word N; emit {N[15:0], R} at RA; R = N[31:16]; RA = N addr+2; stay in HALF.
- SKIP_LO: the first accepted word loads R = W[31:16] and RA = addr+2, emits nothing, and goes to HALF. This is a one-cycle bubble.
- Errors:
  - Word with in_err_i in ALIGNED or SKIP_LO: emit out_err_o = 1, out_is_compressed_o = 0, instr = word, go to ERR.
  - In HALF with uncompressed R: out_err_o = 1 and out_err_plus2_o = 1, at address RA.
- ERR: in_ready_o = 1 and all words are dropped; no output until flush.
- flush_i:
  - Has highest priority over any simultaneous input or output handshake.
  - Same cycle: clears out_valid_o and the residual, and drops the input word.
  - Next state: ALIGNED if flush_addr_i[1] == 0, else SKIP_LO.
- Backpressure:
  - in_ready_o = 0 whenever the output register cannot load (full and not draining).
  - in_ready_o = 0 in HALF while R is compressed.
- Addresses: 32-bit, wrap modulo 2^32. RA = 0xFFFF_FFFE followed by a new word at address 0 is legal.
- Reset mid-operation discards the residual immediately (asynchronous).

Optional Feature:
IBEX_REALIGN_RV32C_EN
- Defined: full behaviour above.
- Undefined (RV32 without C):
  - Only ALIGNED and ERR states exist; every word is emitted whole; out_is_compressed_o = 0.
  - A parcel with [1:0] != 11 is emitted with out_err_o = 0 (the decoder flags it illegal).
  - flush_addr_i[1] == 1 forces a single output with out_err_o = 1, then ERR.

Decomposition:
- ibex_realign_pkg:
  - realign_state_e enum (ALIGNED, HALF, SKIP_LO, ERR).
  - is_compressed function.
  - HALF_W = 16 constant.
- Sub-module ibex_realign_out_reg: one-entry valid/ready register holding instr, addr, is_compressed, err and err_plus2.

Test Plan:
- Aligned words 0x00A00093 @0x100, 0x00B00113 @0x104 -> two 32-bit outputs @0x100 and @0x104, is_compressed = 0, back-to-back.
- Word 0x0001_4505 @0x200 -> c.li @0x200 (0x4505), then c.nop @0x202 (0x0001) with in_ready_o = 0 on that cycle.
- Word 0x0093_4505 @0x300, then 0x0000_0A00 @0x304 -> c.li @0x300, then 32-bit 0x0A000093 @0x302, residual 0x0000 @0x306.
- Flush to 0x402, word 0x0001_FFFF @0x400 -> 1-cycle bubble, then c.nop @0x402 only.
- Uncompressed residual @0x502, next word has in_err_i -> out_err_o = 1 and out_err_plus2_o = 1 @0x502; following words dropped until flush.
- out_ready_i held 0 for 5 cycles with a word pending -> outputs stable, in_ready_o = 0; flush_i asserted in the same cycle as out_ready_i -> nothing delivered.

Source files
------------

// File: rtl/ibex_realign_pkg.sv
// Shared types and helpers for the instruction realigner.
package ibex_realign_pkg;

    localparam int unsigned HALF_W = 16;

    typedef enum logic [1:0] {
        ALIGNED,
        HALF,
        SKIP_LO,
        ERR
    } realign_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        is_compressed;
        logic        err;
        logic        err_plus2;
    } out_entry_t;

    // A parcel is compressed unless its two low bits are both set.
    function automatic logic is_compressed(input logic [1:0] low_bits);
        return low_bits != 2'b11;
    endfunction

endpackage

// File: rtl/ibex_instr_realigner_if.sv
// Fetch-word input and instruction output handshakes of the realigner.
interface ibex_instr_realigner_if;

    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] in_rdata_i;
    logic [31:0] in_addr_i;
    logic        in_err_i;

    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_instr_o;
    logic [31:0] out_addr_o;
    logic        out_is_compressed_o;
    logic        out_err_o;
    logic        out_err_plus2_o;

    // Realigner side.
    modport slave (
        input  in_valid_i, in_rdata_i, in_addr_i, in_err_i, out_ready_i,
        output in_ready_o, out_valid_o, out_instr_o, out_addr_o,
               out_is_compressed_o, out_err_o, out_err_plus2_o
    );

    // Fetch FIFO / decoder side.
    modport master (
        output in_valid_i, in_rdata_i, in_addr_i, in_err_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_instr_o, out_addr_o,
               out_is_compressed_o, out_err_o, out_err_plus2_o
    );

endinterface

// File: rtl/ibex_realign_out_reg.sv
// One-entry valid/ready output register. Flush empties it unconditionally.
module ibex_realign_out_reg
    import ibex_realign_pkg::*;
#(
    parameter bit ResetAll = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       flush_i,
    input  logic       ld_valid_i,
    input  out_entry_t ld_data_i,
    input  logic       out_ready_i,
    output logic       can_load_o,
    output logic       out_valid_o,
    output out_entry_t out_data_o
);

    logic       valid_q;
    out_entry_t data_q;
    logic       ld_en;

    assign can_load_o  = ~valid_q | out_ready_i;
    assign ld_en       = can_load_o & ld_valid_i & ~flush_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    // Valid bit: cleared by flush, otherwise refilled whenever the slot frees up.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (can_load_o) begin
            valid_q <= ld_valid_i;
        end
    end

    if (ResetAll) begin : g_data_rst
        // Payload with reset.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                data_q <= '0;
            end else if (ld_en) begin
                data_q <= ld_data_i;
            end
        end
    end else begin : g_data_nr
        // Payload without reset; only meaningful while valid_q is set.
        always_ff @(posedge clk_i) begin
            if (ld_en) begin
                data_q <= ld_data_i;
            end
        end
    end

endmodule

// File: rtl/ibex_instr_realigner.sv
// Realigns word-aligned fetch words into single instructions for the decoder.
// Compressed-instruction support is built when IBEX_REALIGN_RV32C_EN is defined;
// otherwise every word passes through whole and a half-word redirect is a fault.
module ibex_instr_realigner
    import ibex_realign_pkg::*;
#(
    parameter bit ResetAll = 1'b0
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic [31:0]            flush_addr_i,
    ibex_instr_realigner_if.slave  bus
);

    realign_state_e state_q, state_d;
    logic [31:0]    ra_q, ra_d;
`ifdef IBEX_REALIGN_RV32C_EN
    logic [HALF_W-1:0] res_q, res_d;
`else
    logic              pend_q, pend_d;
`endif

    logic       can_load;
    logic       ld_valid;
    out_entry_t ld_data;
    logic       out_valid;
    out_entry_t out_data;
    logic       unused_flush_addr0;

    assign unused_flush_addr0 = flush_addr_i[0];

    // Control state is always reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ALIGNED;
`ifndef IBEX_REALIGN_RV32C_EN
            pend_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
`ifndef IBEX_REALIGN_RV32C_EN
            pend_q  <= pend_d;
`endif
        end
    end

    if (ResetAll) begin : g_res_rst
        // Residual half-word and its address, with reset.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                ra_q  <= '0;
`ifdef IBEX_REALIGN_RV32C_EN
                res_q <= '0;
`endif
            end else begin
                ra_q  <= ra_d;
`ifdef IBEX_REALIGN_RV32C_EN
                res_q <= res_d;
`endif
            end
        end
    end else begin : g_res_nr
        // Residual half-word and its address, without reset.
        always_ff @(posedge clk_i) begin
            ra_q  <= ra_d;
`ifdef IBEX_REALIGN_RV32C_EN
            res_q <= res_d;
`endif
        end
    end

`ifdef IBEX_REALIGN_RV32C_EN
    // Next state, input acceptance and output load selection.
    always_comb begin
        state_d        = state_q;
        ra_d           = ra_q;
        res_d          = res_q;
        bus.in_ready_o = 1'b0;
        ld_valid       = 1'b0;
        ld_data        = '0;

        if (flush_i) begin
            // Redirect wins over everything; the presented word is swallowed.
            bus.in_ready_o = 1'b1;
            res_d          = '0;
            ra_d           = {flush_addr_i[31:1], 1'b0};
            state_d        = flush_addr_i[1] ? SKIP_LO : ALIGNED;
        end else begin
            unique case (state_q)
                ALIGNED: begin
                    bus.in_ready_o = can_load;
                    if (bus.in_valid_i && can_load) begin
                        ld_valid      = 1'b1;
                        ld_data.instr = bus.in_rdata_i;
                        ld_data.addr  = bus.in_addr_i;
                        if (bus.in_err_i) begin
                            ld_data.err = 1'b1;
                            state_d     = ERR;
                        end else if (is_compressed(bus.in_rdata_i[1:0])) begin
                            ld_data.instr         = {{HALF_W{1'b0}}, bus.in_rdata_i[HALF_W-1:0]};
                            ld_data.is_compressed = 1'b1;
                            res_d                 = bus.in_rdata_i[31:HALF_W];
                            ra_d                  = bus.in_addr_i + 32'd2;
                            state_d               = HALF;
                        end
                    end
                end
                HALF: begin
                    if (is_compressed(res_q[1:0])) begin
                        // Residual is a whole instruction: drain it without touching input.
                        if (can_load) begin
                            ld_valid              = 1'b1;
                            ld_data.instr         = {{HALF_W{1'b0}}, res_q};
                            ld_data.addr          = ra_q;
                            ld_data.is_compressed = 1'b1;
                            state_d               = ALIGNED;
                        end
                    end else begin
                        bus.in_ready_o = can_load;
                        if (bus.in_valid_i && can_load) begin
                            ld_valid      = 1'b1;
                            ld_data.instr = {bus.in_rdata_i[HALF_W-1:0], res_q};
                            ld_data.addr  = ra_q;
                            if (bus.in_err_i) begin
                                ld_data.err       = 1'b1;
                                ld_data.err_plus2 = 1'b1;
                                state_d           = ERR;
                            end else begin
                                res_d = bus.in_rdata_i[31:HALF_W];
                                ra_d  = bus.in_addr_i + 32'd2;
                            end
                        end
                    end
                end
                SKIP_LO: begin
                    // Discard the low parcel of the first word after a half-word redirect.
                    bus.in_ready_o = can_load;
                    if (bus.in_valid_i && can_load) begin
                        if (bus.in_err_i) begin
                            ld_valid      = 1'b1;
                            ld_data.instr = bus.in_rdata_i;
                            ld_data.addr  = bus.in_addr_i + 32'd2;
                            ld_data.err   = 1'b1;
                            state_d       = ERR;
                        end else begin
                            res_d   = bus.in_rdata_i[31:HALF_W];
                            ra_d    = bus.in_addr_i + 32'd2;
                            state_d = HALF;
                        end
                    end
                end
                default: begin
                    // ERR: sink everything until the next redirect.
                    bus.in_ready_o = 1'b1;
                end
            endcase
        end
    end
`else
    // Next state, input acceptance and output load selection (no compressed support).
    always_comb begin
        state_d        = state_q;
        ra_d           = ra_q;
        pend_d         = pend_q;
        bus.in_ready_o = 1'b0;
        ld_valid       = 1'b0;
        ld_data        = '0;

        if (flush_i) begin
            // A half-word target cannot be fetched without C: report it once, then stall in ERR.
            bus.in_ready_o = 1'b1;
            ra_d           = {flush_addr_i[31:1], 1'b0};
            pend_d         = flush_addr_i[1];
            state_d        = flush_addr_i[1] ? ERR : ALIGNED;
        end else begin
            unique case (state_q)
                ALIGNED: begin
                    bus.in_ready_o = can_load;
                    if (bus.in_valid_i && can_load) begin
                        ld_valid      = 1'b1;
                        ld_data.instr = bus.in_rdata_i;
                        ld_data.addr  = bus.in_addr_i;
                        ld_data.err   = bus.in_err_i;
                        if (bus.in_err_i) begin
                            state_d = ERR;
                        end
                    end
                end
                default: begin
                    bus.in_ready_o = 1'b1;
                    if (pend_q && can_load) begin
                        ld_valid     = 1'b1;
                        ld_data.addr = ra_q;
                        ld_data.err  = 1'b1;
                        pend_d       = 1'b0;
                    end
                end
            endcase
        end
    end
`endif

    ibex_realign_out_reg #(
        .ResetAll (ResetAll)
    ) u_out_reg (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .ld_valid_i  (ld_valid),
        .ld_data_i   (ld_data),
        .out_ready_i (bus.out_ready_i),
        .can_load_o  (can_load),
        .out_valid_o (out_valid),
        .out_data_o  (out_data)
    );

    assign bus.out_valid_o         = out_valid;
    assign bus.out_instr_o         = out_data.instr;
    assign bus.out_addr_o          = out_data.addr;
    assign bus.out_is_compressed_o = out_data.is_compressed;
    assign bus.out_err_o           = out_data.err;
    assign bus.out_err_plus2_o     = out_data.err_plus2;

endmodule

// File: tb/tb_ibex_instr_realigner.sv
// Directed bench for ibex_instr_realigner; expectations follow the build's
// IBEX_REALIGN_RV32C_EN setting.
module tb_ibex_instr_realigner;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] flush_addr = '0;
    int          vectors = 0;
    int          miscompares = 0;

    ibex_instr_realigner_if bus();

    ibex_instr_realigner #(
        .ResetAll (1'b0)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .flush_i      (flush),
        .flush_addr_i (flush_addr),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] d, input logic [31:0] a, input logic e);
        bus.in_valid_i = 1'b1;
        bus.in_rdata_i = d;
        bus.in_addr_i  = a;
        bus.in_err_i   = e;
    endtask

    task automatic idle();
        bus.in_valid_i = 1'b0;
        bus.in_err_i   = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] ins, input logic [31:0] a,
                           input logic c, input logic e, input logic e2);
        logic [67:0] obs;
        logic [67:0] exp;
        obs = {bus.out_valid_o, bus.out_instr_o, bus.out_addr_o,
               bus.out_is_compressed_o, bus.out_err_o, bus.out_err_plus2_o};
        exp = {1'b1, ins, a, c, e, e2};
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed {v,instr,addr,c,err,err2}=%h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_empty(input string tag);
        vectors++;
        assert (bus.out_valid_o === 1'b0) else begin
            miscompares++;
            $error("FAIL %s: observed out_valid=%b, expected 0", tag, bus.out_valid_o);
        end
    endtask

    task automatic chk_rdy(input string tag, input logic exp);
        #1;
        vectors++;
        assert (bus.in_ready_o === exp) else begin
            miscompares++;
            $error("FAIL %s: observed in_ready=%b, expected %b", tag, bus.in_ready_o, exp);
        end
    endtask

    initial begin
        bus.in_valid_i  = 1'b0;
        bus.in_rdata_i  = '0;
        bus.in_addr_i   = '0;
        bus.in_err_i    = 1'b0;
        bus.out_ready_i = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_empty("reset_valid");
        chk_rdy("reset_ready", 1'b1);
        rst_n = 1'b1;
        step();

        // Two aligned 32-bit words, back-to-back
        put(32'h00A00093, 32'h100, 1'b0);
        step();
        chk_out("aligned0", 32'h00A00093, 32'h100, 1'b0, 1'b0, 1'b0);
        put(32'h00B00113, 32'h104, 1'b0);
        chk_rdy("aligned_rdy", 1'b1);
        step();
        chk_out("aligned1", 32'h00B00113, 32'h104, 1'b0, 1'b0, 1'b0);
        idle();
        step();
        chk_empty("aligned_done");

        // Backpressure for 5 cycles, then flush together with out_ready
        bus.out_ready_i = 1'b0;
        put(32'h00C00193, 32'h300, 1'b0);
        step();
        chk_out("bp_load", 32'h00C00193, 32'h300, 1'b0, 1'b0, 1'b0);
        put(32'h00D00213, 32'h304, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk_rdy("bp_rdy", 1'b0);
            step();
            chk_out("bp_hold", 32'h00C00193, 32'h300, 1'b0, 1'b0, 1'b0);
        end
        flush = 1'b1;
        flush_addr = 32'h400;
        bus.out_ready_i = 1'b1;
        step();
        chk_empty("bp_flush");
        flush = 1'b0;
        idle();
        step();
        chk_empty("bp_after_flush");

`ifdef IBEX_REALIGN_RV32C_EN
        // c.li then c.nop from the same word; input stalls while residual drains
        put(32'h00014505, 32'h200, 1'b0);
        step();
        chk_out("cli_200", 32'h00004505, 32'h200, 1'b1, 1'b0, 1'b0);
        put(32'h00A00093, 32'h204, 1'b0);
        chk_rdy("cnop_stall", 1'b0);
        step();
        chk_out("cnop_202", 32'h00000001, 32'h202, 1'b1, 1'b0, 1'b0);
        chk_rdy("after_cnop_rdy", 1'b1);
        step();
        chk_out("word_204", 32'h00A00093, 32'h204, 1'b0, 1'b0, 1'b0);
        idle();
        step();
        chk_empty("c_pair_done");

        // Straddling 32-bit instruction
        put(32'h00934505, 32'h300, 1'b0);
        step();
        chk_out("cli_300", 32'h00004505, 32'h300, 1'b1, 1'b0, 1'b0);
        put(32'h00000A00, 32'h304, 1'b0);
        chk_rdy("straddle_rdy", 1'b1);
        step();
        chk_out("straddle_302", 32'h0A000093, 32'h302, 1'b0, 1'b0, 1'b0);
        idle();
        step();
        chk_out("resid_306", 32'h00000000, 32'h306, 1'b1, 1'b0, 1'b0);
        step();
        chk_empty("straddle_done");

        // Redirect to a half-word: one bubble, then only the upper parcel
        flush = 1'b1;
        flush_addr = 32'h402;
        step();
        flush = 1'b0;
        put(32'h0001FFFF, 32'h400, 1'b0);
        step();
        chk_empty("skip_bubble");
        idle();
        step();
        chk_out("skip_402", 32'h00000001, 32'h402, 1'b1, 1'b0, 1'b0);
        step();
        chk_empty("skip_done");

        // Error in the second half of an unaligned instruction
        put(32'h00130001, 32'h500, 1'b0);
        step();
        chk_out("cnop_500", 32'h00000001, 32'h500, 1'b1, 1'b0, 1'b0);
        put(32'h12345678, 32'h504, 1'b1);
        chk_rdy("err2_rdy", 1'b1);
        step();
        chk_out("err_plus2", 32'h56780013, 32'h502, 1'b0, 1'b1, 1'b1);
        put(32'h00A00093, 32'h508, 1'b0);
        chk_rdy("err_sink_rdy", 1'b1);
        step();
        chk_empty("err_drop0");
        step();
        chk_empty("err_drop1");
        idle();

        // Address wrap: residual at 0xFFFFFFFE completed by the word at 0
        flush = 1'b1;
        flush_addr = 32'hFFFF_FFFE;
        step();
        flush = 1'b0;
        put(32'h0093FFFF, 32'hFFFF_FFFC, 1'b0);
        step();
        chk_empty("wrap_bubble");
        put(32'h00000A00, 32'h0, 1'b0);
        chk_rdy("wrap_rdy", 1'b1);
        step();
        chk_out("wrap_fffe", 32'h0A000093, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        idle();
        step();
        chk_out("wrap_0002", 32'h00000000, 32'h2, 1'b1, 1'b0, 1'b0);
        step();
        chk_empty("wrap_done");
`else
        // Compressed-looking word passes through whole, no error
        put(32'h00014505, 32'h200, 1'b0);
        step();
        chk_out("noc_whole", 32'h00014505, 32'h200, 1'b0, 1'b0, 1'b0);
        idle();
        step();
        chk_empty("noc_whole_done");

        // Bus error, then everything dropped
        put(32'hDEADBEEF, 32'h500, 1'b1);
        step();
        chk_out("noc_err", 32'hDEADBEEF, 32'h500, 1'b0, 1'b1, 1'b0);
        put(32'h00A00093, 32'h504, 1'b0);
        chk_rdy("noc_err_rdy", 1'b1);
        step();
        chk_empty("noc_err_drop0");
        idle();
        step();
        chk_empty("noc_err_drop1");

        // Half-word redirect: one error output, then silence
        flush = 1'b1;
        flush_addr = 32'h602;
        step();
        flush = 1'b0;
        step();
        chk_out("noc_misalign", 32'h0, 32'h602, 1'b0, 1'b1, 1'b0);
        step();
        chk_empty("noc_misalign_once");

        // Aligned redirect recovers
        flush = 1'b1;
        flush_addr = 32'h700;
        step();
        flush = 1'b0;
        put(32'h00E00293, 32'h700, 1'b0);
        step();
        chk_out("noc_recover", 32'h00E00293, 32'h700, 1'b0, 1'b0, 1'b0);
        idle();
        step();
        chk_empty("noc_recover_done");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
